// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and helpers for the instruction fetch path.
//   NOP_INSN      : instruction word shown on an empty/reset output queue
//   fetch_state_e : fetch sequencer states
//   fetch_pair_t  : {pc, instruction} pair carried from the buffer to decode
//   pc_in_window  : true when a fetch PC is aligned and inside the buffer
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_pair_t;

    // The offset is taken with 32-bit wrap, so a PC below base becomes a huge
    // offset and fails the depth compare rather than aliasing into the window.
    function automatic logic pc_in_window(
        input logic [31:0] pc,
        input logic [31:0] base,
        input logic [31:0] depth,
        input int unsigned step_bits
    );
        logic [31:0] off;
        logic [31:0] mask;
        off  = pc - base;
        mask = (32'd1 << step_bits) - 32'd1;
        return ((off & mask) == 32'd0) && ((off >> step_bits) < depth);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Two-entry FIFO of fetch pairs between the instruction buffer and decode.
// Push and pop may happen in the same cycle; flush empties it at once.
//   clk, rst  : clock, synchronous active-high reset (queue empty, NOP head)
//   push      : write push_data at the tail
//   pop       : drop the head
//   flush     : discard all entries (wins over push/pop)
//   push_data : pair to write
//   count     : number of valid entries (0..2)
//   head      : oldest entry, valid when count != 0
// -----------------------------------------------------------------------------
module fetch_queue
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  fetch_pair_t push_data,
    output logic [1:0]  count,
    output fetch_pair_t head
);

    fetch_pair_t entry_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage itself is reset, not just the pointers, because
            // the head entry drives out_pc/out_ins straight out of reset.
            for (int i = 0; i < 2; i++) begin
                entry_q[i] <= '{pc: 32'h0000_0000, ins: NOP_INSN};
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                entry_q[wr_ptr_q] <= push_data;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign count = count_q;
    assign head  = entry_q[rd_ptr_q];

    // The issue rule upstream keeps the queue from ever overflowing.
    queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && count_q == 2'd2));

    queue_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && !flush && count_q == 2'd0));

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Fetch sequencer for a synchronous-read instruction buffer. Generates the
// fetch PC, absorbs the buffer's one-cycle read latency and hands
// {pc, instruction} pairs to decode over valid/ready through a 2-entry queue.
// Redirects discard everything queued or in flight; a fetch PC outside the
// buffer window (or misaligned) parks the block in FAULT until a redirect.
//   clk, rst       : clock, synchronous active-high reset
//   start          : leave IDLE and begin fetching at BOOT_PC
//   redirect_valid : branch/jump taken, redirect_pc is the new target
//   ib_pc          : address presented to the buffer (holds when not issuing)
//   ib_base        : constant BASE for the buffer
//   ib_ins         : buffer data for the address issued on the previous edge
//   out_valid/out_ready/out_pc/out_ins : decode handshake and head pair
//   fault, fault_pc: window/alignment fault flag and offending PC
// -----------------------------------------------------------------------------
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] BOOT_PC = 32'h0000_0000,
    parameter logic [31:0] BASE    = 32'h0000_0000,
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned PC_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ib_pc,
    output logic [31:0] ib_base,
    input  logic [31:0] ib_ins,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_ins,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam int unsigned STEP_BITS = $clog2(PC_STEP);
    localparam logic [31:0] STEP_W    = 32'(PC_STEP);
    localparam logic [31:0] DEPTH_W   = 32'(DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ib_pc_q, ib_pc_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic         inflight_q, inflight_d;

    logic         push;
    logic         pop;
    logic         flush;
    logic [1:0]   count;
    logic [2:0]   pending;
    logic         room;
    fetch_pair_t  push_data;
    fetch_pair_t  head;

    // Slots committed after this edge: queued + arriving - leaving. A new issue
    // is only allowed when its data is guaranteed a free slot next cycle.
    assign pop       = out_valid & out_ready;
    assign pending   = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    assign room      = (pending < 3'd2);
    // ib_pc_q is still the address whose data is on ib_ins this cycle.
    assign push_data = '{pc: ib_pc_q, ins: ib_ins};

    fetch_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data (push_data),
        .count     (count),
        .head      (head)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        ib_pc_d    = ib_pc_q;
        fault_pc_d = fault_pc_q;
        inflight_d = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = BOOT_PC;
                end
            end

            RUN: begin
                if (redirect_valid) begin
                    // Queue cleared and the arriving word dropped; no issue
                    // this cycle, the new target is issued next cycle.
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                end else begin
                    push = inflight_q;
                    if (room) begin
                        if (!pc_in_window(pc_q, BASE, DEPTH_W, STEP_BITS)) begin
                            state_d    = FAULT;
                            fault_pc_d = pc_q;
                            flush      = 1'b1;
                            push       = 1'b0;
                        end else begin
                            ib_pc_d    = pc_q;
                            inflight_d = 1'b1;
                            pc_d       = pc_q + STEP_W;
                        end
                    end
                end
            end

            FAULT: begin
                if (redirect_valid) begin
                    state_d = RUN;
                    pc_d    = redirect_pc;
                    flush   = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                flush   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= BOOT_PC;
            ib_pc_q    <= BOOT_PC;
            fault_pc_q <= 32'h0000_0000;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ib_pc_q    <= ib_pc_d;
            fault_pc_q <= fault_pc_d;
            inflight_q <= inflight_d;
        end
    end

    assign ib_pc     = ib_pc_q;
    assign ib_base   = BASE;
    assign out_valid = (count != 2'd0);
    assign out_pc    = head.pc;
    assign out_ins   = head.ins;
    assign fault     = (state_q == FAULT);
    assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl: directed scenarios with literal
// expectations, then randomized start/redirect/back-pressure/reset traffic
// compared every cycle against a queue-based behavioural model.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam logic [31:0] BOOT_PC    = 32'h0000_0000;
    localparam logic [31:0] BASE       = 32'h0000_0000;
    localparam int          DEPTH      = 128;
    localparam int          PC_STEP    = 4;
    localparam logic [31:0] STEP_W     = 32'd4;
    localparam logic [31:0] DEPTH_W    = 32'd128;
    localparam logic [31:0] WINDOW_END = 32'h0000_0200;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    typedef enum int {M_IDLE, M_RUN, M_FAULT} mode_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ib_pc;
    logic [31:0] ib_base;
    logic [31:0] ib_ins;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_ins;
    logic        fault;
    logic [31:0] fault_pc;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state
    mode_e       m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_ib_pc;
    logic [31:0] m_fpc;
    bit          m_inflight;
    bit          m_fresh;
    pair_t       m_q[$];

    always #5 clk = ~clk;

    fetch_ctrl #(
        .BOOT_PC (BOOT_PC),
        .BASE    (BASE),
        .DEPTH   (DEPTH),
        .PC_STEP (PC_STEP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ib_pc          (ib_pc),
        .ib_base        (ib_base),
        .ib_ins         (ib_ins),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_ins        (out_ins),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    // Buffer contents: word k holds k*0x00010003 + 0x5A000000.
    function automatic logic [31:0] buf_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = (addr - BASE) / STEP_W;
        return idx * 32'h0001_0003 + 32'h5A00_0000;
    endfunction

    // Synchronous-read buffer seen through its address register (ib_pc).
    assign ib_ins = buf_word(ib_pc);

    function automatic bit fetchable(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - BASE;
        return (off % STEP_W == 32'd0) && (off / STEP_W < DEPTH_W);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit pop_now;
        bit room;
        if (rst) begin
            m_mode     = M_IDLE;
            m_pc       = BOOT_PC;
            m_ib_pc    = BOOT_PC;
            m_fpc      = 32'h0;
            m_inflight = 1'b0;
            m_fresh    = 1'b1;
            m_q.delete();
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (start) begin
                        m_mode = M_RUN;
                        m_pc   = BOOT_PC;
                    end
                end
                M_RUN: begin
                    pop_now = (m_q.size() != 0) && out_ready;
                    if (redirect_valid) begin
                        m_q.delete();
                        m_inflight = 1'b0;
                        m_pc       = redirect_pc;
                    end else begin
                        room = (m_q.size() + int'(m_inflight) - int'(pop_now)) < 2;
                        if (pop_now) void'(m_q.pop_front());
                        if (m_inflight) begin
                            m_q.push_back(pair_t'{pc: m_ib_pc, ins: buf_word(m_ib_pc)});
                            m_fresh = 1'b0;
                        end
                        m_inflight = 1'b0;
                        if (room) begin
                            if (!fetchable(m_pc)) begin
                                m_mode = M_FAULT;
                                m_fpc  = m_pc;
                                m_q.delete();
                            end else begin
                                m_inflight = 1'b1;
                                m_ib_pc    = m_pc;
                                m_pc       = m_pc + STEP_W;
                            end
                        end
                    end
                end
                default: begin
                    if (redirect_valid) begin
                        m_mode = M_RUN;
                        m_pc   = redirect_pc;
                    end
                end
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
                check("ib_base", ib_base, BASE);
                check("ib_pc", ib_pc, m_ib_pc);
                check("fault", 32'(fault), 32'(m_mode == M_FAULT));
                if (m_mode == M_FAULT) check("fault_pc", fault_pc, m_fpc);
                if (m_q.size() != 0) begin
                    check("out_pc", out_pc, m_q[0].pc);
                    check("out_ins", out_ins, m_q[0].ins);
                end else if (m_fresh) begin
                    check("idle_out_pc", out_pc, 32'h0);
                    check("idle_out_ins", out_ins, NOP);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        tick();
        tick();
        cmp_en = 1'b1;

        // Reset values
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_ins", out_ins, 32'h0000_0013);
        check("rst_ib_pc", ib_pc, 32'h0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_fault_pc", fault_pc, 32'h0);

        // Start latency and streaming
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_c0_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_c1_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_c2_valid", 32'(out_valid), 32'd1);
        check("lat_c2_pc", out_pc, 32'h0);
        check("lat_c2_ins", out_ins, 32'h5A00_0000);
        tick();
        check("stream_pc1", out_pc, 32'h4);
        check("stream_ins1", out_ins, 32'h5A01_0003);
        tick();
        check("stream_pc2", out_pc, 32'h8);
        repeat (5) tick();

        // Back-pressure from the first valid cycle
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        repeat (5) tick();
        check("bp_head_pc", out_pc, 32'h0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_no_issue", ib_pc, 32'h4);
        out_ready = 1'b1;
        tick();
        check("bp_rel_pc1", out_pc, 32'h4);
        tick();
        check("bp_rel_pc2", out_pc, 32'h8);

        // Redirect with a full queue
        out_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b1;
        check("redir_flush", 32'(out_valid), 32'd0);
        tick();
        check("redir_gap", 32'(out_valid), 32'd0);
        tick();
        check("redir_pc0", out_pc, 32'h20);
        tick();
        check("redir_pc1", out_pc, 32'h24);

        // Run off the end of the window
        redirect_valid = 1'b1; redirect_pc = 32'h1F0;
        tick();
        redirect_valid = 1'b0;
        repeat (5) tick();
        check("win_fault", 32'(fault), 32'd1);
        check("win_fault_pc", fault_pc, WINDOW_END);
        check("win_valid", 32'(out_valid), 32'd0);
        repeat (2) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        check("win_clear", 32'(fault), 32'd0);
        tick(); tick();
        check("win_resume", out_pc, 32'h0);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_fault_pc", fault_pc, 32'h6);

        // Reset mid-run with a full queue
        redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        repeat (4) tick();
        check("full_before_rst", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_pc", out_pc, 32'h0);
        check("mrst_ins", out_ins, 32'h0000_0013);
        check("mrst_ib_pc", ib_pc, 32'h0);
        check("mrst_fault", 32'(fault), 32'd0);
        out_ready = 1'b1;
        tick(); tick();
        check("idle_no_issue", ib_pc, 32'h0);

        // Redirect in IDLE is ignored; start still fetches BOOT_PC
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        check("idle_redir_ignored", out_pc, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst            = ($urandom_range(0, 199) == 0);
            start          = ($urandom_range(0, 9) == 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 9))
                0:       redirect_pc = WINDOW_END + 32'($urandom_range(0, 3)) * STEP_W;
                1:       redirect_pc = BASE + 32'($urandom_range(0, 511));
                2, 3:    redirect_pc = BASE + 32'($urandom_range(120, 127)) * STEP_W;
                default: redirect_pc = BASE + 32'($urandom_range(0, 127)) * STEP_W;
            endcase
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
